mem_access_stage: RTL

- MEM-stage data-memory access unit. Sits between the EX/MEM pipeline register and the MEM_WB register.
- Takes the ALU result as the address, plus the store data and memory control signals.
- Performs byte, halfword and word loads and stores on an internal word-organised RAM with a configurable number of wait states.
- Drives the extended load data into MEM_WB and raises a pipeline stall while an access is in flight.

---
 rtl/mem_access_stage_pkg.sv | 8 +
 rtl/mem_access_stage_load_align.sv | 18 +
 rtl/mem_access_stage.sv | 79 +++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: size encodings, FSM states and counter width shared by the MEM stage
package mem_access_stage_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int WAIT_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_load_align: picks the byte/half/word lane of a RAM word and sign- or zero-extends it
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    data = size[1] ? word : size == SIZE_HALF ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit on a word RAM with WAIT_STATES busy cycles per access.
// Define MEM_ACCESS_COUNT_EN to add the Access_Count_out completed-access counter.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] WriteData_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemSigned_in,
  output logic [31:0] Mem_ReadData_out,
  output logic        Stall_out,
  output logic        Misaligned_out
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] Access_Count_out
`endif
);
  state_t                 state, state_n;
  logic [WAIT_CNT_W-1:0]  cnt;
  logic [31:0]            rdata, ld, wdata;
  logic [31:0]            mem [2**ADDR_WIDTH];
  logic [3:0]             be;
  logic [ADDR_WIDTH-1:0]  idx;
  logic                   mis, req, acc, unused_addr;
  assign unused_addr = ^ALU_Result_in[31:ADDR_WIDTH+2];
  always_comb begin
    idx = ALU_Result_in[ADDR_WIDTH+1:2];
    mis = (MemSize_in == SIZE_HALF & ALU_Result_in[0]) | (MemSize_in[1] & |ALU_Result_in[1:0]);
    req = (MemRead_in | MemWrite_in) & ~mis;
    acc = state == IDLE ? req & (WAIT_STATES == 0) : state == BUSY & cnt == WAIT_CNT_W'(1);
    state_n = state == IDLE ? (req ? (WAIT_STATES == 0 ? DONE : BUSY) : IDLE)
            : state == BUSY ? (cnt == WAIT_CNT_W'(1) ? DONE : BUSY) : IDLE;
    be = MemSize_in[1] ? 4'hf : MemSize_in == SIZE_HALF ? (ALU_Result_in[1] ? 4'hc : 4'h3)
       : 4'b0001 << ALU_Result_in[1:0];
    wdata = MemSize_in[1] ? WriteData_in : MemSize_in == SIZE_HALF ? {2{WriteData_in[15:0]}}
          : {4{WriteData_in[7:0]}};
  end
  assign Stall_out        = (state == IDLE & req) | state == BUSY;
  assign Misaligned_out   = state == IDLE & mis & (MemRead_in | MemWrite_in);
  assign Mem_ReadData_out = state == DONE ? rdata : '0;
  mem_load_align u_align (
    .word(mem[idx]),
    .lane(ALU_Result_in[1:0]),
    .size(MemSize_in),
    .sgn (MemSigned_in),
    .data(ld)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE & req) cnt <= WAIT_CNT_W'(WAIT_STATES);
      else if (state == BUSY) cnt <= cnt - 1'b1;
      if (acc) rdata <= MemWrite_in ? '0 : ld;
    end
  end
  // stores land only on the access edge, so a reset mid-access drops them
  always_ff @(posedge clk) begin
    if (!reset & acc & MemWrite_in)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
`ifdef MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) Access_Count_out <= '0;
    else if (state == DONE) Access_Count_out <= Access_Count_out + 1'b1;
  end
`endif
endmodule
